// File: rtl/rx_data_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_rx_pkg
// Shared types and constants for the RX data buffer.
// Revision: 1.0
// ============================================================================
package uart_rx_pkg;

    localparam int RX_DEFAULT_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } rx_state_t;

    typedef struct packed {
`ifdef UART_RX_PARITY_EN
        logic                       perr;
`endif
        logic                       ferr;
        logic [RX_DEFAULT_SIZE-1:0] data;
    } rx_entry_t;

endpackage
`default_nettype wire

// File: rtl/rx_data_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface : rx_data_buffer_if
// Serial-side inputs and host-side FIFO outputs of the RX data buffer.
// Revision: 1.0
// ============================================================================
interface rx_data_buffer_if #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
);
    logic                     rxd;
    logic                     rxc_tick;
    logic                     rxen;
    logic                     rxrdy;
    logic                     frame_error;
    logic                     data_read;
    logic                     clr_err;
    logic [SIZE-1:0]          data_out;
    logic                     data_valid;
    logic                     ferr_out;
    logic                     overrun;
    logic [$clog2(DEPTH):0]   count;
`ifdef UART_RX_PARITY_EN
    logic                     perr;
`endif

    modport master (
        output rxd, rxc_tick, rxen, rxrdy, frame_error, data_read, clr_err,
        input  data_out, data_valid, ferr_out, overrun, count
`ifdef UART_RX_PARITY_EN
        , input perr
`endif
    );

    modport slave (
        input  rxd, rxc_tick, rxen, rxrdy, frame_error, data_read, clr_err,
        output data_out, data_valid, ferr_out, overrun, count
`ifdef UART_RX_PARITY_EN
        , output perr
`endif
    );
endinterface
`default_nettype wire

// File: rtl/rx_data_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module  : rx_sync_fifo
// Show-ahead synchronous FIFO with extra-MSB pointers.
// Revision: 1.0
// ============================================================================
module rx_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             w_pop;
    logic             w_push;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // A pop frees the head slot in the same cycle, so a full FIFO may still accept a push.
    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + 1'b1;
            if (w_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
endmodule
`default_nettype wire

// File: rtl/rx_data_buffer.sv
`default_nettype none
// ============================================================================
// Module  : rx_data_buffer
// Assembles LSB-first serial bits into words and queues them with error flags.
// Optional parity checking: define UART_RX_PARITY_EN.
// Revision: 1.0
// ============================================================================
module rx_data_buffer
    import uart_rx_pkg::*;
#(
    parameter int SIZE  = RX_DEFAULT_SIZE,
    parameter int DEPTH = 4
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    rx_data_buffer_if.slave bus
);
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = SIZE + 1;
`else
    localparam int NBITS = SIZE;
`endif
    localparam int CW = $clog2(NBITS + 2);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] c_CNT_FULL = CW'(NBITS);
    localparam logic [CW-1:0] c_CNT_SAT  = CW'(NBITS + 1);

    typedef struct packed {
`ifdef UART_RX_PARITY_EN
        logic            perr;
`endif
        logic            ferr;
        logic [SIZE-1:0] data;
    } entry_t;

    rx_state_t        state_q, state_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             rxrdy_q;
    logic             fe_q;
    logic             overrun_q;
    logic             w_commit_ev;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic [AW:0]      w_count;
    entry_t           w_wentry;
    entry_t           w_rentry;

    assign w_commit_ev = bus.rxrdy & ~rxrdy_q;
    assign w_drop      = w_push & w_full & ~bus.data_read;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.rxen) state_d = COLLECT;
            COLLECT: if (w_commit_ev) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        w_push   = 1'b0;
        case (state_q)
            IDLE: if (bus.rxen) bitcnt_d = '0;
            COLLECT: begin
                if (bus.rxen && bus.rxc_tick) begin
                    shift_d = {bus.rxd, shift_q[NBITS-1:1]};
                    if (bitcnt_q != c_CNT_SAT) bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            COMMIT:  w_push = 1'b1;
            default: w_push = 1'b0;
        endcase
    end

    // Frame error is only guaranteed valid on the RXRDY rising edge, so hold it for COMMIT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            bitcnt_q  <= '0;
            rxrdy_q   <= 1'b0;
            fe_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            rxrdy_q  <= bus.rxrdy;
            if (w_commit_ev) fe_q <= bus.frame_error;
            if (w_drop)            overrun_q <= 1'b1;
            else if (bus.clr_err)  overrun_q <= 1'b0;
        end
    end

    always_comb begin
        w_wentry      = '0;
        w_wentry.data = shift_q[SIZE-1:0];
        w_wentry.ferr = fe_q | (bitcnt_q != c_CNT_FULL);
`ifdef UART_RX_PARITY_EN
        w_wentry.perr = (^shift_q[SIZE-1:0]) ^ shift_q[SIZE] ^ PARITY_ODD;
`endif
    end

    rx_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (bus.data_read),
        .wdata_i (w_wentry),
        .rdata_o (w_rentry),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Stale memory contents are masked so an empty FIFO always presents zeros.
    assign bus.data_out   = w_empty ? '0 : w_rentry.data;
    assign bus.ferr_out   = ~w_empty & w_rentry.ferr;
    assign bus.data_valid = ~w_empty;
    assign bus.overrun    = overrun_q;
    assign bus.count      = w_count;
`ifdef UART_RX_PARITY_EN
    assign bus.perr       = ~w_empty & w_rentry.perr;
`endif
endmodule
`default_nettype wire

// File: doc/rx_data_buffer.md
Name: rx_data_buffer

Overview:
Downstream neighbour of the RX control unit. Assembles received serial bits into words, LSB first, while the control unit holds RXEN high, sampling on a bit-centre strobe. Commits each word, with its frame-error status, into a small synchronous FIFO when the control unit raises RXRDY. Presents words to the host side over a show-ahead valid/read interface with sticky overrun reporting.

Parameters:
SIZE, 8, data bits per frame; must match the control unit's SIZE.
DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
CLK  in  1  single clock for all logic.
RST  in  1  synchronous, active-high reset.
RXD  in  1  serial line, already synchronised to CLK.
RXC_TICK  in  1  one-cycle strobe at each bit centre, CLK domain.
RXEN  in  1  control unit: high while data bits are being received.
RXRDY  in  1  control unit: low during a frame, rises at frame end.
FRAME_ERROR  in  1  control unit: stop-bit error, valid when RXRDY rises.
DATA_READ  in  1  host pops the head entry; ignored when DATA_VALID=0.
CLR_ERR  in  1  clears OVERRUN.
DATA_OUT  out  SIZE  head-of-FIFO data word (show-ahead).
DATA_VALID  out  1  FIFO not empty.
FERR_OUT  out  1  frame-error flag stored with the head entry.
OVERRUN  out  1  sticky: a word was dropped because the FIFO was full.
COUNT  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, synchronous and dominant over all other inputs:
  - State=IDLE; shift register and bit count cleared; FIFO emptied.
  - DATA_VALID=0, DATA_OUT=0, FERR_OUT=0, OVERRUN=0, COUNT=0.
  - A reset mid-frame discards the partial word.
- Edge detection: RXRDY is registered internally. A commit event is a rising edge of RXRDY (prev=0, now=1).
- FSM states: IDLE, COLLECT, COMMIT.
  - IDLE -> COLLECT when RXEN=1; bit count is cleared on entry.
  - COLLECT: on each cycle with RXEN=1 and RXC_TICK=1:
    - shift = {RXD, shift[SIZE-1:1]};
    - bit count increments, saturating at SIZE+1.
  - COLLECT -> COMMIT on a commit event.
  - COMMIT lasts exactly one cycle, then returns to IDLE.
- Short or long frames: if bit count != SIZE at COMMIT, the entry is still pushed, with its ferr bit forced to 1. Otherwise the stored ferr bit equals FRAME_ERROR.
- Push rule, evaluated in the COMMIT cycle:
  - Not full: entry {ferr, shift} is written.
  - Full and DATA_READ=1 in the same cycle: pop and push both occur; COUNT is unchanged.
  - Full and DATA_READ=0: the entry is dropped and OVERRUN is set the next cycle.
- Latency: a committed word is visible on DATA_OUT with DATA_VALID=1 in the cycle after COMMIT.
- Pop: DATA_READ=1 with DATA_VALID=1 advances the read pointer. The next entry appears the following cycle.
- Empty pop: DATA_READ is ignored; no pointer change, no error.
- Simultaneous push and pop when empty: push only. The word becomes valid next cycle.
- Pointers: $clog2(DEPTH)+1 bits, wrap naturally. Full when the MSBs differ and the lower bits are equal.
- OVERRUN clearing: CLR_ERR=1 clears it next cycle. If CLR_ERR and a new drop occur in the same cycle, set wins.
- A commit event arriving while in IDLE, without any preceding RXEN, pushes nothing.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0) and output PERR (1 bit, head-entry parity error).
  - Expects SIZE+1 bits per frame; the final collected bit is parity.
  - Stored perr = ^data ^ parity_bit ^ PARITY_ODD.
  - A bit count != SIZE+1 forces ferr=1.
  - The FIFO entry widens by one bit; PERR resets to 0.
- Not defined: no PERR port and no parity logic; the behaviour is exactly as above.

Decomposition:
- Package uart_rx_pkg:
  - rx_state_t enum {IDLE, COLLECT, COMMIT};
  - rx_entry_t packed struct {perr (conditional), ferr, data[SIZE-1:0]};
  - constant RX_DEFAULT_SIZE=8.
- Sub-module rx_sync_fifo:
  - parameterised on width and DEPTH;
  - ports: push, pop, wdata, rdata, full, empty, count;
  - contains the pointer and full/empty logic.
- rx_data_buffer instantiates rx_sync_fifo and owns the FSM, shifter and error flags.

Test Plan:
- Frame 0xA5, 8 ticks with RXEN=1 (LSB first: 1,0,1,0,0,1,0,1), then an RXRDY rise with FRAME_ERROR=0 -> next cycle DATA_OUT=0xA5, DATA_VALID=1, FERR_OUT=0, COUNT=1.
- Same frame with FRAME_ERROR=1 -> FERR_OUT=1 and DATA_OUT=0xA5. Only 7 ticks, then commit -> entry pushed with FERR_OUT=1.
- Five frames 0x01..0x05 with DEPTH=4 and no reads -> COUNT=4, OVERRUN=1, DATA_OUT=0x01. Pops return 0x01..0x04, then DATA_VALID=0. CLR_ERR -> OVERRUN=0.
- FIFO full, commit of 0x06 coinciding with DATA_READ=1 -> COUNT stays 4, no OVERRUN, 0x06 is read last.
- RST asserted after 4 ticks of frame 0xFF, then frame 0x3C -> only 0x3C appears, COUNT=1. DATA_READ while empty -> no change.
- With UART_RX_PARITY_EN, PARITY_ODD=0: frame 0x07 with parity 1 -> PERR=0; parity 0 -> PERR=1.
